scmi_mbox_responder: RTL
========================

SCMI_MBOX_RESPONDER -- requirements
Module: scmi_mbox_responder

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 32, meaning request address width.
REQ-002 The block SHALL have parameter DataWidth, default 32, meaning request data width; only 32 is supported.
REQ-003 The block SHALL have parameter NumMsgWords, default 32, meaning the number of 32-bit shared-message words (1..32).
REQ-004 The block SHALL have port clk_i, input, width 1, the single clock.
REQ-005 The block SHALL have port rst_ni, input, width 1, the reset; reset is asynchronous and active-low.
REQ-006 The block SHALL have port req_valid_i, input, width 1, request valid.
REQ-007 The block SHALL have port req_ready_o, output, width 1, request accepted when high together with req_valid_i.
REQ-008 The block SHALL have port req_addr_i, input, width AddrWidth, byte address; only bits [11:0] are decoded (4 KiB window).
REQ-009 The block SHALL have port req_write_i, input, width 1, 1 = write and 0 = read.
REQ-010 The block SHALL have port req_wdata_i, input, width 32, write data.
REQ-011 The block SHALL have port req_wstrb_i, input, width 4, byte strobes.
REQ-012 The block SHALL have port rsp_valid_o, output, width 1, response valid.
REQ-013 The block SHALL have port rsp_ready_i, input, width 1, response consumed when high together with rsp_valid_o.
REQ-014 The block SHALL have port rsp_rdata_o, output, width 32, read data.
REQ-015 The block SHALL have port rsp_error_o, output, width 1, access error.
REQ-016 The block SHALL have port doorbell_irq_o, output, width 1, level interrupt to the platform (responder) side.
REQ-017 The block SHALL have port completion_irq_o, output, width 1, level interrupt to the agent (initiator) side.

Function
REQ-018 Register map (offset[11:0]): 0x000..4*NumMsgWords-4 MSG[i]; 0x080 DOORBELL (RW, bit0); 0x084 COMPLETION (RW, bit0); 0x088 STATUS (RO, {30'b0, completion_q, doorbell_q}).
REQ-019 The FSM SHALL have states IDLE and RESP: req_ready_o=1 only in IDLE; on accept -> RESP; in RESP, rsp_valid_o=1 and the state is held until rsp_ready_i=1 -> IDLE.
REQ-020 Latency SHALL be exactly 1 cycle: response valid in the cycle after acceptance, with at most one outstanding request.
REQ-021 rsp_rdata_o and rsp_error_o SHALL be registered at acceptance and held stable while in RESP.
REQ-022 Writes SHALL take effect at the acceptance clock edge; a read issued immediately afterwards SHALL return the new value.
REQ-023 MSG writes SHALL update only the bytes whose wstrb bit is set; wstrb=0 SHALL be a legal no-op that returns no error.
REQ-024 DOORBELL/COMPLETION writes SHALL load bit0 from wdata[0] only if wstrb[0]=1; bits [31:1] SHALL be ignored on write and read as 0.
REQ-025 The following SHALL give rsp_error_o=1, rdata=0, and no state change: addr[1:0]!=0; offset in 4*NumMsgWords..0x07C; offset >= 0x08C; write to STATUS.
REQ-026 doorbell_irq_o SHALL equal doorbell_q and completion_irq_o SHALL equal completion_q, combinationally from the flops.
REQ-027 A write of 1 to DOORBELL SHALL leave COMPLETION unchanged, and vice versa; clearing is software's responsibility.
REQ-028 Reads SHALL have no side effects.

Reset
REQ-029 During reset (rst_ni=0), and independently of clk_i: state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, doorbell_q=0, completion_q=0, all MSG words=0.
REQ-030 Reset asserted while in RESP SHALL drop the pending response; after release the block SHALL be in IDLE with no response issued.

Verification
REQ-031 Write MSG[3]=0xDEADBEEF with wstrb=0xF, then write 0x11223344 with wstrb=0x2, then read -> 0xDEAD33EF, error=0, each response one cycle after acceptance.
REQ-032 Write DOORBELL=1 -> doorbell_irq_o=1 in the cycle after acceptance; STATUS read -> 0x1; write COMPLETION=1 -> completion_irq_o=1; STATUS -> 0x3; write DOORBELL=0 -> STATUS 0x2.
REQ-033 Read 0x08C, read 0x002, and write 0x088 -> each returns error=1, rdata=0, with STATUS unchanged.
REQ-034 Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_rdata_o held stable and req_ready_o=0 throughout; accept on the 6th cycle -> IDLE on the next edge.
REQ-035 Assert rst_ni=0 mid-RESP after DOORBELL=1 -> rsp_valid_o=0 and doorbell_irq_o=0 immediately; after release, MSG[0] reads 0x0.

Source files
------------

// File: rtl/scmi_mbox_responder.sv
// SCMI shared-memory mailbox responder: message words, doorbell and
// completion flags behind a valid/ready request port with a one-cycle response.
module scmi_mbox_responder #(
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 32,
  parameter int NumMsgWords = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic                 doorbell_irq_o,
  output logic                 completion_irq_o
);

  localparam int IdxW = (NumMsgWords > 1) ? $clog2(NumMsgWords) : 1;

  typedef enum logic {IDLE, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] msg_q [NumMsgWords];
  logic        doorbell_q, completion_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic [11:0]     off;
  logic [IdxW-1:0] idx;
  logic            accept;
  logic            msg_hit, db_hit, cp_hit, st_hit;
  logic            err;
  logic [31:0]     rd_val;
  logic            unused_addr;

  assign off         = req_addr_i[11:0];
  assign idx         = off[IdxW+1:2];
  assign unused_addr = ^req_addr_i[AddrWidth-1:12];

  assign req_ready_o      = (state_q == IDLE);
  assign rsp_valid_o      = (state_q == RESP);
  assign rsp_rdata_o      = rdata_q;
  assign rsp_error_o      = error_q;
  assign doorbell_irq_o   = doorbell_q;
  assign completion_irq_o = completion_q;

  assign accept  = req_valid_i & req_ready_o;
  assign msg_hit = (off[11:2] < 10'(NumMsgWords));
  assign db_hit  = (off == 12'h080);
  assign cp_hit  = (off == 12'h084);
  assign st_hit  = (off == 12'h088);

  // Misaligned, unmapped, or an attempt to write the read-only status word.
  assign err = (off[1:0] != 2'b00)
             | ~(msg_hit | db_hit | cp_hit | st_hit)
             | (st_hit & req_write_i);

  always_comb begin
    rd_val = 32'h0;
    unique case (1'b1)
      msg_hit: rd_val = msg_q[idx];
      db_hit:  rd_val = {31'b0, doorbell_q};
      cp_hit:  rd_val = {31'b0, completion_q};
      st_hit:  rd_val = {30'b0, completion_q, doorbell_q};
      default: rd_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rdata_q      <= 32'h0;
      error_q      <= 1'b0;
      doorbell_q   <= 1'b0;
      completion_q <= 1'b0;
      for (int i = 0; i < NumMsgWords; i++) msg_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        error_q <= err;
        rdata_q <= (err | req_write_i) ? 32'h0 : rd_val;
        if (req_write_i && !err) begin
          if (msg_hit) begin
            for (int b = 0; b < 4; b++)
              if (req_wstrb_i[b]) msg_q[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
          end
          if (db_hit && req_wstrb_i[0]) doorbell_q   <= req_wdata_i[0];
          if (cp_hit && req_wstrb_i[0]) completion_q <= req_wdata_i[0];
        end
      end
    end
  end

endmodule
